pipelined_adder: RTL
====================

Name: pipelined_adder

Overview:
- Parametrised, pipelined WIDTH-bit adder/subtractor.
- The carry chain is cut into STAGES equal slices, with one register stage per slice. Valid/ready handshakes sit on both sides.
- Serves as the shared arithmetic core for the multi-cycle ALU paths.
- Full throughput: one operation per cycle. Backpressure stalls the pipeline without dropping or duplicating operations.

Parameters:
WIDTH, 32, operand and result width in bits; must be a multiple of STAGES.
STAGES, 4, pipeline depth and number of carry slices; slice width SW = WIDTH/STAGES; 1 <= STAGES <= WIDTH.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation presented on a, b, cin, sub
in_ready  output  1  block accepts operation this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in, used only when sub=0
sub  input  1  1: a - b (a + ~b + 1); 0: a + b + cin
out_valid  output  1  result fields valid
out_ready  input  1  consumer accepts result this cycle
sum  output  WIDTH  result, modulo 2^WIDTH
cout  output  1  carry out of MSB; for sub, 1 means no borrow
overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB
zero  output  1  sum == 0

Behaviour:
- Reset: asynchronous when rst_n=0, released synchronously by design.
  - All stage valid bits, out_valid, sum, cout, overflow and zero are 0.
  - in_ready is 1 after reset, because the pipeline is empty.
- Operand preparation at accept (in_valid & in_ready):
  - b_eff = sub ? ~b : b.
  - c0 = sub ? 1 : cin.
- Stage k (0..STAGES-1):
  - Adds slice k of a and b_eff plus the incoming carry.
  - Registers the slice-k sum bits together with the already-computed lower slices.
  - Passes forward the carry and the unprocessed upper slices of a and b_eff (skewed registers).
  - Stage 0 takes its carry from c0.
- Final stage registers:
  - sum: full result.
  - cout: carry out of bit WIDTH-1.
  - overflow: carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - zero: computed on the completed sum before registering.
- Latency:
  - An operation accepted in cycle t appears with out_valid=1 in cycle t+STAGES when no stall occurs.
  - STAGES=1 gives one-cycle registered latency.
- Handshake per stage:
  - v[k] is stage k's valid bit. Stage STAGES-1 drives out_valid.
  - en[k] = ~v[k] | en[k+1], and en[STAGES-1] = ~out_valid | out_ready.
  - A stage loads when en[k]=1. Its v[k] takes the upstream valid: stage 0 takes in_valid, stage k>0 takes v[k-1].
  - When en[k]=0 the stage holds its data and valid.
  - in_ready = en[0], so it is combinational from out_ready through the enable chain.
  - Bubbles compress: an empty stage accepts even while downstream is stalled.
- Output stability: while out_valid=1 and out_ready=0, sum, cout, overflow and zero hold constant.
- Inputs ignored: a, b, cin and sub are don't-care when in_valid=0 or in_ready=0.
- Simultaneous accept/retire: with a full pipeline and out_ready=1, the block accepts one operation and retires one in the same cycle (steady state).
- Reset mid-operation: all in-flight operations are discarded and out_valid drops immediately (asynchronously). No partial result is ever emitted.
- Ordering: results emerge strictly in acceptance order, and each accepted operation produces exactly one result.

Test Plan:
- Carry wrap (WIDTH=32, STAGES=4): a=0xFFFFFFFF, b=0x00000000, cin=1, sub=0, out_ready=1 -> 4 cycles later out_valid=1, sum=0x00000000, cout=1, overflow=0, zero=1.
- Subtract with borrow: a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0, overflow=0, zero=0. Then a=7, b=5, sub=1 -> sum=2, cout=1.
- Signed overflow:
  - a=0x7FFFFFFF, b=1, sub=0 -> sum=0x80000000, overflow=1, cout=0.
  - a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, overflow=1, cout=1.
- Streaming: 8 back-to-back random operations with out_ready=1 -> results on 8 consecutive cycles starting at accept+4, in order, each matching a reference model; in_ready constantly 1.
- Backpressure: fill the pipeline, then hold out_ready=0 for 3 cycles -> in_ready=0 once all 4 stages are valid, and outputs stay stable. Release -> every operation is delivered exactly once, in order. Also insert in_valid gaps and check that bubbles compress.
- Reset and config:
  - Assert rst_n=0 with 3 operations in flight -> out_valid=0 immediately, and after release no stale result appears.
  - Repeat the carry-wrap and streaming scenarios at WIDTH=8, STAGES=1 and WIDTH=16, STAGES=8 -> latencies 1 and 8 respectively.

Source files
------------

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor: the carry chain is cut into STAGES equal
// slices, one register stage per slice, with valid/ready flow control on both ends.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int SW = WIDTH / STAGES;

    // Handshake: a transfer happens on a rising edge where valid & ready are both 1;
    // valid never waits for ready, and a stalled stage holds its data and valid bit.

    // Skewed per-stage registers: a_q/b_q keep the operands (upper slices still
    // pending), s_q holds the sum bits completed so far, c_q the slice carry.
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] v_q;
    logic              ovf_q;
    logic              zero_q;

    logic [WIDTH-1:0]  a_in [STAGES];
    logic [WIDTH-1:0]  b_in [STAGES];
    logic [WIDTH-1:0]  s_in [STAGES];
    logic [WIDTH-1:0]  s_nx [STAGES];
    logic [STAGES-1:0] c_in;
    logic [STAGES-1:0] c_nx;
    logic [STAGES-1:0] v_in;
    logic [STAGES-1:0] en;
    logic              ovf_nx;
    logic              zero_nx;

    always_comb begin
        logic          full;
        logic [SW:0]   slice;
        // A stage may load if the consumer takes the result or any stage from it
        // downstream is empty, so bubbles compress under backpressure.
        full = 1'b1;
        for (int k = STAGES - 1; k >= 0; k--) begin
            full  = full & v_q[k];
            en[k] = out_ready | ~full;
        end

        a_in[0] = a;
        b_in[0] = sub ? ~b : b;
        s_in[0] = '0;
        c_in[0] = sub | cin;
        v_in[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            s_in[k] = s_q[k-1];
            c_in[k] = c_q[k-1];
            v_in[k] = v_q[k-1];
        end

        for (int k = 0; k < STAGES; k++) begin
            slice = {1'b0, a_in[k][k*SW +: SW]} + {1'b0, b_in[k][k*SW +: SW]}
                  + {{SW{1'b0}}, c_in[k]};
            s_nx[k]              = s_in[k];
            s_nx[k][k*SW +: SW]  = slice[SW-1:0];
            c_nx[k]              = slice[SW];
        end

        // Carry into the MSB is recovered from the MSB sum bit and its operands.
        ovf_nx  = a_in[STAGES-1][WIDTH-1] ^ b_in[STAGES-1][WIDTH-1]
                ^ s_nx[STAGES-1][WIDTH-1] ^ c_nx[STAGES-1];
        zero_nx = (s_nx[STAGES-1] == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            c_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (en[k]) begin
                    v_q[k] <= v_in[k];
                    a_q[k] <= a_in[k];
                    b_q[k] <= b_in[k];
                    s_q[k] <= s_nx[k];
                    c_q[k] <= c_nx[k];
                end
            end
            if (en[STAGES-1]) begin
                ovf_q  <= ovf_nx;
                zero_q <= zero_nx;
            end
        end
    end

    assign in_ready  = en[0];
    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule
